// File: rtl/min_max_pkg.sv
// Shared definitions for the min/max bar-graph LED driver.
// Contents:
//   COM_NORMAL / COM_LINEAR / COM_OFF / COM_ON : 2-bit mode command encodings
//   led_count(valsize)                          : number of LEDs driven for a value width
package min_max_pkg;

    localparam logic [1:0] COM_NORMAL = 2'b00;
    localparam logic [1:0] COM_LINEAR = 2'b01;
    localparam logic [1:0] COM_OFF    = 2'b10;
    localparam logic [1:0] COM_ON     = 2'b11;

    // One LED per representable value.
    function automatic int led_count(input int valsize);
        return 32'sd1 <<< valsize;
    endfunction

endpackage : min_max_pkg

// File: rtl/min_max_decode.sv
// Combinational LED pattern generator for the min/max bar-graph driver.
// Ports:
//   com     : mode command (normal / linear / off / on)
//   max_val : window upper bound, unsigned
//   min_val : window lower bound, unsigned
//   osc     : oscillator level applied to dimmed LEDs
//   val     : displayed value, unsigned
//   pattern : LED pattern, bit i = LED i
// Configuration: macro MIN_MAX_ERRNO_EN enables the ERRNO fault selector;
// without it ERRNO has no effect.
module min_max_decode
    import min_max_pkg::*;
#(
    parameter int VALSIZE = 4,
    parameter int ERRNO   = 0
) (
    input  logic [1:0]                     com,
    input  logic [VALSIZE-1:0]             max_val,
    input  logic [VALSIZE-1:0]             min_val,
    input  logic                           osc,
    input  logic [VALSIZE-1:0]             val,
    output logic [led_count(VALSIZE)-1:0]  pattern
);

    localparam int LEDS = led_count(VALSIZE);

`ifdef MIN_MAX_ERRNO_EN
    localparam int ERR_SEL = ERRNO;
`else
    // Fault selector pinned to zero: the production build is always correct.
    localparam int ERR_SEL = ERRNO * 0;
`endif

    localparam bit ERR_MIN_ZERO = (ERR_SEL == 1);
    localparam bit ERR_DIM_ONE  = (ERR_SEL == 2);
    localparam bit ERR_SWAP     = (ERR_SEL == 3);
    localparam bit ERR_OPEN_MAX = (ERR_SEL == 4);

    // Operands widened by one bit so that index arithmetic near the top
    // LED never wraps.
    logic [VALSIZE:0] min_s;
    logic [VALSIZE:0] max_s;
    logic [VALSIZE:0] val_s;
    logic [VALSIZE:0] on_lo_s;
    logic             dim_s;
    logic             in_window_s;

    assign min_s   = {1'b0, min_val};
    assign max_s   = {1'b0, max_val};
    assign val_s   = {1'b0, val};
    assign on_lo_s = ERR_MIN_ZERO ? {(VALSIZE+1){1'b0}} : min_s;
    assign dim_s   = ERR_DIM_ONE ? 1'b1 : osc;

    // Value must lie inside [min, max]; an inverted window never matches.
    always_comb begin
        in_window_s = 1'b0;
        if (ERR_OPEN_MAX) begin
            in_window_s = (min_s <= val_s) && (val_s < max_s);
        end else begin
            in_window_s = (min_s <= val_s) && (val_s <= max_s);
        end
    end

    // Per-LED pattern selection by mode.
    always_comb begin
        logic [VALSIZE:0] idx_s;
        logic             upper_ok_s;
        pattern    = {LEDS{1'b0}};
        idx_s      = {(VALSIZE+1){1'b0}};
        upper_ok_s = 1'b0;
        case (com)
            COM_NORMAL: begin
                if (in_window_s) begin
                    for (int i = 0; i < LEDS; i++) begin
                        idx_s = i[VALSIZE:0];
                        if (ERR_OPEN_MAX) begin
                            upper_ok_s = (idx_s < max_s);
                        end else begin
                            upper_ok_s = (idx_s <= max_s);
                        end
                        if ((idx_s >= on_lo_s) && (idx_s <= val_s)) begin
                            pattern[i] = 1'b1;
                        end else if ((idx_s > val_s) && upper_ok_s) begin
                            pattern[i] = dim_s;
                        end else begin
                            pattern[i] = 1'b0;
                        end
                    end
                end else begin
                    pattern = {LEDS{1'b0}};
                end
            end
            COM_LINEAR: begin
                for (int i = 0; i < LEDS; i++) begin
                    idx_s      = i[VALSIZE:0];
                    pattern[i] = (idx_s <= val_s);
                end
            end
            COM_OFF: begin
                pattern = ERR_SWAP ? {LEDS{1'b1}} : {LEDS{1'b0}};
            end
            COM_ON: begin
                pattern = ERR_SWAP ? {LEDS{1'b0}} : {LEDS{1'b1}};
            end
            default: begin
                pattern = {LEDS{1'b0}};
            end
        endcase
    end

endmodule : min_max_decode

// File: rtl/min_max_top.sv
// Bar-graph LED driver: decodes mode/window/value into a registered LED vector.
// Ports:
//   clk_i  : clock, all state on rising edge
//   rst_i  : synchronous active-high reset, clears the LED vector
//   com_i  : mode command (00 normal, 01 linear, 10 off, 11 on)
//   max_i  : window upper bound
//   min_i  : window lower bound
//   osc_i  : oscillator level for dimmed LEDs
//   val_i  : displayed value
//   leds_o : registered LED vector, bit i = LED i (one cycle latency)
// Configuration: macro MIN_MAX_ERRNO_EN enables the ERRNO fault selector.
module min_max_top
    import min_max_pkg::*;
#(
    parameter int VALSIZE = 4,
    parameter int ERRNO   = 0
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [1:0]                     com_i,
    input  logic [VALSIZE-1:0]             max_i,
    input  logic [VALSIZE-1:0]             min_i,
    input  logic                           osc_i,
    input  logic [VALSIZE-1:0]             val_i,
    output logic [led_count(VALSIZE)-1:0]  leds_o
);

    localparam int LEDS = led_count(VALSIZE);

    logic [LEDS-1:0] pattern_s;
    logic [LEDS-1:0] leds_r;

    min_max_decode #(
        .VALSIZE (VALSIZE),
        .ERRNO   (ERRNO)
    ) u_decode (
        .com     (com_i),
        .max_val (max_i),
        .min_val (min_i),
        .osc     (osc_i),
        .val     (val_i),
        .pattern (pattern_s)
    );

    // Output register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            leds_r <= {LEDS{1'b0}};
        end else begin
            leds_r <= pattern_s;
        end
    end

    assign leds_o = leds_r;

endmodule : min_max_top

// File: tb/tb_min_max_top.sv
// Self-checking bench for min_max_top: a VALSIZE=4 and a VALSIZE=10 instance
// checked against a range-based behavioural model.
module tb_min_max_top;

    logic        clk;
    logic        rst;

    logic [1:0]  n_com;
    logic [3:0]  n_max, n_min, n_val;
    logic        n_osc;
    logic [15:0] n_leds;

    logic [1:0]    w_com;
    logic [9:0]    w_max, w_min, w_val;
    logic          w_osc;
    logic [1023:0] w_leds;

    int errors = 0;
    int checks = 0;

    min_max_top #(.VALSIZE(4), .ERRNO(0)) u_narrow (
        .clk_i (clk), .rst_i (rst), .com_i (n_com), .max_i (n_max),
        .min_i (n_min), .osc_i (n_osc), .val_i (n_val), .leds_o (n_leds)
    );

    min_max_top #(.VALSIZE(10), .ERRNO(0)) u_wide (
        .clk_i (clk), .rst_i (rst), .com_i (w_com), .max_i (w_max),
        .min_i (w_min), .osc_i (w_osc), .val_i (w_val), .leds_o (w_leds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: whole-vector result built from the mode's on / dimmed index ranges.
    function automatic logic [1023:0] model(input int vs, input int com, input int mn,
                                             input int mx, input int v, input bit osc);
        logic [1023:0] r;
        int n;
        r = '0;
        n = 1 << vs;
        case (com)
            0: if (mn <= v && v <= mx) begin
                   for (int i = mn; i <= v; i++) r[i] = 1'b1;
                   for (int i = v + 1; i <= mx; i++) r[i] = osc;
               end
            1: for (int i = 0; i <= v; i++) r[i] = 1'b1;
            3: for (int i = 0; i < n; i++) r[i] = 1'b1;
            default: r = '0;
        endcase
        return r;
    endfunction

    // Advance one clock and sample away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_n(input logic [1:0] c, input int mn, input int mx, input int v, input bit o);
        n_com = c; n_min = mn[3:0]; n_max = mx[3:0]; n_val = v[3:0]; n_osc = o;
    endtask

    task automatic check_n(input string tag, input logic [15:0] exp);
        check_eq(tag, {240'd0, n_leds}, {240'd0, exp});
    endtask

    task automatic check_n_model(input string tag);
        logic [1023:0] e;
        e = model(4, int'(n_com), int'(n_min), int'(n_max), int'(n_val), n_osc);
        check_eq(tag, {240'd0, n_leds}, {240'd0, e[15:0]});
    endtask

    task automatic check_w_model(input string tag);
        logic [1023:0] e;
        e = model(10, int'(w_com), int'(w_min), int'(w_max), int'(w_val), w_osc);
        for (int k = 0; k < 4; k++)
            check_eq(tag, w_leds[k*256 +: 256], e[k*256 +: 256]);
    endtask

    initial begin
        int mn, mx, v;
        logic [1023:0] e;

        rst = 1'b1;
        set_n(2'b11, 0, 0, 0, 1'b0);
        w_com = 2'b11; w_min = '0; w_max = '0; w_val = '0; w_osc = 1'b0;

        // Reset overrides com=11
        step();
        check_n("reset_narrow", 16'h0000);
        check_eq("reset_wide", w_leds[255:0], 256'd0);
        rst = 1'b0;
        step();
        check_n("after_reset_on", 16'hFFFF);

        // Normal mode
        set_n(2'b00, 3, 12, 8, 1'b1); step();
        check_n("normal_osc1", 16'h1FF8);
        set_n(2'b00, 3, 12, 8, 1'b0); step();
        check_n("normal_osc0", 16'h01F8);

        // Out of range / inverted window
        set_n(2'b00, 0, 14, 15, 1'b1); step();
        check_n("val_above_max", 16'h0000);
        set_n(2'b00, 5, 4, 5, 1'b1); step();
        check_n("min_gt_max", 16'h0000);

        // Boundaries
        set_n(2'b00, 2, 9, 9, 1'b1); step();
        check_n("val_eq_max", 16'h03FC);
        set_n(2'b00, 6, 6, 6, 1'b1); step();
        check_n("single_led", 16'h0040);
        set_n(2'b00, 4, 15, 15, 1'b1); step();
        check_n("val_top", 16'hFFF0);
        set_n(2'b00, 0, 15, 0, 1'b1); step();
        check_n("val_zero_full_window", 16'hFFFF);

        // Oscillator toggling
        set_n(2'b00, 5, 10, 7, 1'b0); step();
        check_n("osc_0", 16'h00E0);
        set_n(2'b00, 5, 10, 7, 1'b1); step();
        check_n("osc_1", 16'h07E0);
        set_n(2'b00, 5, 10, 7, 1'b0); step();
        check_n("osc_0_again", 16'h00E0);

        // Linear / off / on
        set_n(2'b01, 9, 2, 15, 1'b0); step();
        check_n("linear_15", 16'hFFFF);
        set_n(2'b01, 9, 2, 0, 1'b1); step();
        check_n("linear_0", 16'h0001);
        set_n(2'b01, 0, 0, 5, 1'b0); step();
        check_n("linear_5", 16'h003F);
        set_n(2'b10, 0, 15, 7, 1'b1); step();
        check_n("off", 16'h0000);
        set_n(2'b11, 0, 0, 0, 1'b0); step();
        check_n("on", 16'hFFFF);

        // Mid-operation reset
        rst = 1'b1; step();
        check_n("mid_reset", 16'h0000);
        rst = 1'b0; step();
        check_n("mid_reset_release", 16'hFFFF);

        // Wide window, VALSIZE=10
        w_com = 2'b00; w_min = 10'd100; w_max = 10'd1000; w_val = 10'd500; w_osc = 1'b1;
        step();
        e = '0;
        for (int i = 100; i <= 1000; i++) e[i] = 1'b1;
        for (int k = 0; k < 4; k++)
            check_eq("wide_window", w_leds[k*256 +: 256], e[k*256 +: 256]);

        // Random sweep: wide in-window normal mode, narrow across all modes
        for (int t = 0; t < 1000; t++) begin
            mn = int'($urandom_range(0, 1022));
            mx = int'($urandom_range(mn + 1, 1023));
            v  = int'($urandom_range(mn, mx));
            w_com = 2'b00; w_min = mn[9:0]; w_max = mx[9:0]; w_val = v[9:0];
            w_osc = 1'($urandom);
            n_com = 2'($urandom); n_min = 4'($urandom); n_max = 4'($urandom);
            n_val = 4'($urandom); n_osc = 1'($urandom);
            if (t % 8 == 0) begin
                n_com = 2'b00;
                n_min = n_val;
                n_max = n_val + 4'($urandom_range(0, 2));
            end
            step();
            check_w_model("rand_wide");
            check_n_model("rand_narrow");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_min_max_top

// File: doc/min_max_top.md
# min_max_top

Bar-graph LED driver. From a 2-bit command, a `[min, max]` window, a value and an oscillator input, it produces a registered 2**VALSIZE-bit LED vector. It is a leaf block between the user-input registers and the LED pads of the display board.

## Interface
Parameters:
- `VALSIZE`, default 4: width of min/max/value; LED count is 2**VALSIZE.
- `ERRNO`, default 0: fault-injection selector for verification; 0 = correct behaviour.

Ports:
- `clk_i` in 1: single clock, all state on rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `com_i` in 2: mode command.
- `max_i` in VALSIZE: window upper bound, unsigned.
- `min_i` in VALSIZE: window lower bound, unsigned.
- `osc_i` in 1: oscillator level used for dimmed LEDs.
- `val_i` in VALSIZE: displayed value, unsigned.
- `leds_o` out 2**VALSIZE: LED vector; bit i = LED i.

## Operation
The pattern is computed combinationally and registered into `leds_o`. Index i ranges over 0..2**VALSIZE-1, and all comparisons are unsigned.
- `com_i`=00, normal mode:
  - If min_i <= val_i <= max_i: bit i = 1 for min_i <= i <= val_i; bit i = osc_i for val_i < i <= max_i; all other bits 0.
  - Otherwise (value outside the window, or min_i > max_i): all bits 0.
- `com_i`=01, linear mode: bit i = 1 for 0 <= i <= val_i, else 0. min_i, max_i and osc_i are ignored.
- `com_i`=10: all LEDs off (all 0).
- `com_i`=11: all LEDs on (all 1).

Boundary cases:
- val_i = max_i: no dimmed LEDs.
- min_i = max_i = val_i: exactly one LED on.
- val_i = 2**VALSIZE-1: the val+1 range is empty; no wrap-around, so index arithmetic must be done at VALSIZE+1 bits.
- osc_i toggling every cycle makes the dimmed segment blink at that rate, giving perceived low intensity.

## Timing
- Reset value: `leds_o` = 0 on the first rising edge with `rst_i`=1. Reset overrides all inputs and is valid mid-operation.
- Latency: exactly 1 cycle. Inputs sampled at edge n appear on `leds_o` after edge n and are stable for the whole following cycle.
- There is no handshake. Inputs are sampled every cycle, and a change in any input, including osc_i, shows up one cycle later.
- There is no other state and no FSM.

## Configuration
- Macro `MIN_MAX_ERRNO_EN`:
  - When defined: non-zero ERRNO values select deliberate faults for bench qualification:
    - 1: normal-mode on-range starts at 0 instead of min_i.
    - 2: dimmed bits forced to 1 instead of osc_i.
    - 3: modes 10 and 11 swapped.
    - 4: inclusive upper bound on max_i dropped.
    - Other non-zero values behave as 0.
  - When undefined: ERRNO is ignored and the block is always correct.

## Structure
- Package `min_max_pkg` holds:
  - Mode constants COM_NORMAL=2'b00, COM_LINEAR=2'b01, COM_OFF=2'b10, COM_ON=2'b11, or an equivalent enum.
  - A helper function computing the LED count from VALSIZE.
- Sub-module `min_max_decode` is a purely combinational pattern generator carrying the ERRNO logic. `min_max_top` wraps it with the output register and reset.

## Test plan
Use VALSIZE=4 unless stated; check `leds_o` one cycle after each stimulus.
- Reset: `rst_i`=1 with com=11 -> `leds_o`=0. Release reset -> all-ones on the next cycle.
- Normal: com=00, min=3, max=12, val=8, osc=1 -> bits 3..12 = 1, rest 0. Same with osc=0 -> bits 3..8 = 1, rest 0.
- Out of range: com=00, min=0, max=14, val=15 -> all 0. min=5, max=4, val=5 -> all 0.
- Oscillator: com=00, min=5, max=10, val=7, osc toggling 0/1/0 -> bits 8..10 = 000/111/000 on successive cycles; bits 5..7 stay 1.
- Linear/off/on: com=01, val=15 -> 0xFFFF; com=01, val=0 -> 0x0001; com=10 -> 0; com=11 -> 0xFFFF.
- Wide window: VALSIZE=10, com=00, min=100, max=1000, val=500, osc=1 -> bits 100..1000 = 1, rest 0. Also sweep 1000 random cycles with min < max and val in [min, max] against a model.
